fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32 pipeline: owns the PC, issues instruction-memory requests and drives the IF/ID register.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants used by the fetch stage.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ       = 2'd0,
    WAIT      = 2'd1,
    DROP_REQ  = 2'd2,
    DROP_WAIT = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding slot for an instruction response that lands while IF/ID is stalled.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  logic            rd,
  input  logic            clr,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [31:0]     wr_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
    end else if (rd) begin
      valid <= 1'b0;
    end
  end

  // Payload carries no reset; it is only observed while valid is set.
  always_ff @(posedge clk) begin
    if (wr && !clr) begin
      pc    <= wr_pc;
      instr <= wr_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC ownership, single-outstanding imem fetch, redirect/stall handling and the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [31:0]     if_id_instr_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            run_q;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic            resp_accept;
  logic            skid_wr;
  logic            skid_rd;

  // run_q keeps the request low through reset without a path from rst_n to the port.
  assign imem_req_o  = run_q && (((state_q == REQ) && !skid_valid) || (state_q == DROP_REQ));
  assign imem_addr_o = (state_q == REQ) ? pc_q : req_pc_q;

  assign resp_accept = (state_q == WAIT) && imem_rvalid_i;
  assign skid_wr     = resp_accept && pc_stall_i && !redirect_i;
  assign skid_rd     = skid_valid && !pc_stall_i && !redirect_i;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (skid_wr),
    .rd       (skid_rd),
    .clr      (redirect_i),
    .wr_pc    (req_pc_q),
    .wr_instr (imem_rdata_i),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      run_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      REQ: begin
        if (imem_req_o && imem_gnt_i) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
        end
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          // An ungranted request must stay stable, so its address moves to req_pc_q.
          if (imem_req_o && !imem_gnt_i) begin
            state_d  = DROP_REQ;
            req_pc_d = pc_q;
          end else if (imem_req_o) begin
            state_d = DROP_WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid_i)   state_d = REQ;
        else if (redirect_i) state_d = DROP_WAIT;
        if (redirect_i) pc_d = redirect_pc_i;
      end
      DROP_REQ: begin
        if (imem_gnt_i) state_d = DROP_WAIT;
        if (redirect_i) pc_d = redirect_pc_i;
      end
      DROP_WAIT: begin
        if (imem_rvalid_i) state_d = REQ;
        if (redirect_i) pc_d = redirect_pc_i;
      end
      default: state_d = REQ;
    endcase
  end

  // IF/ID register: redirect > stall > skid > fresh response > bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid_o <= 1'b0;
      if_id_pc_o    <= '0;
      if_id_instr_o <= NOP_INSTR;
    end else if (redirect_i) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end else if (pc_stall_i) begin
      if_id_valid_o <= if_id_valid_o;
    end else if (skid_valid) begin
      if_id_valid_o <= 1'b1;
      if_id_pc_o    <= skid_pc;
      if_id_instr_o <= skid_instr;
    end else if (resp_accept) begin
      if_id_valid_o <= 1'b1;
      if_id_pc_o    <= req_pc_q;
      if_id_instr_o <= imem_rdata_i;
    end else begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a small imem responder model.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o, if_id_instr_o;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_stall_i    (pc_stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_instr_o (if_id_instr_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          edge_cnt = 0;
  logic        auto_gnt, rvalid_noise, pending, drop_next, last_gnt;
  int          resp_delay, rv_cnt;
  logic [31:0] pend_addr, last_gnt_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // One clock: drive imem, take the edge, update the responder and scoreboard.
  task automatic step();
    logic g, rv, req_b, stall_e, redir_e;
    logic [31:0] ga;
    exp_t e;
    req_b = imem_req_o;
    g     = auto_gnt && imem_req_o;
    ga    = imem_addr_o;
    rv    = pending && (rv_cnt <= 1);
    imem_gnt_i    = g;
    imem_rvalid_i = rv || (rvalid_noise && !pending);
    imem_rdata_i  = rv ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    stall_e = pc_stall_i;
    redir_e = redirect_i;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (pending) begin
      if (rv) pending = 1'b0;
      else    rv_cnt--;
    end
    last_gnt      = g;
    last_gnt_addr = ga;
    if (g) begin
      pending   = 1'b1;
      rv_cnt    = resp_delay;
      pend_addr = ga;
      if (drop_next) drop_next = 1'b0;
      else           sb_q.push_back({ga, mem_word(ga)});
    end
    if (redir_e) begin
      if (req_b && !g) drop_next = 1'b1;
      sb_q.delete();
    end
    if (!stall_e && !redir_e && if_id_valid_o) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got valid pc=%h instr=%h, expected no instruction", if_id_pc_o, if_id_instr_o);
      end else begin
        e = sb_q.pop_front();
        if (if_id_pc_o !== e.pc || if_id_instr_o !== e.instr) begin
          n_fail++;
          $display("FAIL sb_ifid: got pc=%h instr=%h, expected pc=%h instr=%h", if_id_pc_o, if_id_instr_o, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pc_stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    auto_gnt = 1'b1; rvalid_noise = 1'b0; resp_delay = 1;
    pending = 1'b0; drop_next = 1'b0; last_gnt = 1'b0; last_gnt_addr = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [31:0] a, input string nm);
    int k;
    k = 0;
    do begin step(); k++; end while (!(last_gnt && last_gnt_addr == a) && k < 40);
    if (!(last_gnt && last_gnt_addr == a)) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no grant seen for addr %h within %0d cycles", nm, a, k);
    end
  endtask

  task automatic wait_valid(input logic [31:0] a, input string nm);
    int k;
    k = 0;
    do begin step(); k++; end while (!(if_id_valid_o && if_id_pc_o == a) && k < 40);
    if (!(if_id_valid_o && if_id_pc_o == a)) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: IF/ID never showed pc %h within %0d cycles", nm, a, k);
    end
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0; auto_gnt = 1'b0; rvalid_noise = 1'b0;
    while ((sb_q.size() != 0 || pending) && k < 30) begin step(); k++; end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected instructions never delivered, expected 0", nm, sb_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_req_o, if_id_valid_o} !== 2'b00 || if_id_pc_o !== 32'h0 || if_id_instr_o !== NOP_INSTR) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b valid=%b pc=%h instr=%h, expected 0 0 00000000 00000013",
               imem_req_o, if_id_valid_o, if_id_pc_o, if_id_instr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h, expected 1 00000000", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_streaming();
    int first_gnt, first_vld, ngnt;
    logic [31:0] exp_addr;
    do_reset();
    rvalid_noise = 1'b1;
    first_gnt = -1; first_vld = -1; ngnt = 0; exp_addr = 32'h0;
    for (int i = 0; i < 40 && ngnt < 5; i++) begin
      step();
      if (last_gnt) begin
        n_cmp++;
        if (last_gnt_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL stream_addr: got %h, expected %h", last_gnt_addr, exp_addr);
        end
        if (first_gnt < 0) first_gnt = edge_cnt;
        exp_addr += 32'd4;
        ngnt++;
      end
      if (if_id_valid_o && first_vld < 0) first_vld = edge_cnt;
    end
    n_cmp++;
    if (ngnt != 5 || first_vld - first_gnt + 1 != 2) begin
      n_fail++;
      $display("FAIL stream_latency: got %0d grants, valid %0d edges after gnt, expected 5 grants and 2 edges",
               ngnt, first_vld - first_gnt + 1);
    end
    drain("stream_drain");
  endtask

  task automatic test_stall_skid();
    do_reset();
    wait_valid(32'h4, "skid_prefill");
    pc_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h4 || if_id_instr_o !== mem_word(32'h4)) begin
        n_fail++;
        $display("FAIL skid_frozen: cycle %0d got valid=%b pc=%h, expected 1 00000004", i, if_id_valid_o, if_id_pc_o);
      end
      if (i > 0) begin
        n_cmp++;
        if (imem_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL skid_no_req: cycle %0d got req=%b, expected 0", i, imem_req_o);
        end
      end
    end
    pc_stall_i = 1'b0;
    step();
    n_cmp++;
    if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h8 || imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin
      n_fail++;
      $display("FAIL skid_release: got valid=%b pc=%h req=%b addr=%h, expected 1 00000008 1 0000000c",
               if_id_valid_o, if_id_pc_o, imem_req_o, imem_addr_o);
    end
    drain("skid_drain");
  endtask

  task automatic test_redirect_wait();
    int k;
    do_reset();
    resp_delay = 3;
    wait_gnt(32'h0, "rdw_first_gnt");
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    n_cmp++;
    if (imem_req_o !== 1'b0 || if_id_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_dropwait: got req=%b valid=%b, expected 0 0", imem_req_o, if_id_valid_o);
    end
    k = 0;
    while (pending && k < 10) begin
      step(); k++;
      n_cmp++;
      if (if_id_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rdw_discard: got valid=%b pc=%h, expected valid 0", if_id_valid_o, if_id_pc_o);
      end
    end
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL rdw_refetch: got req=%b addr=%h, expected 1 00000100", imem_req_o, imem_addr_o);
    end
    wait_valid(32'h100, "rdw_target");
    drain("rdw_drain");
  endtask

  task automatic test_redirect_req();
    int k;
    do_reset();
    wait_gnt(32'hC, "rdr_pre");
    auto_gnt = 1'b0;
    k = 0;
    while (!imem_req_o && k < 10) begin step(); k++; end
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL rdr_pending_req: got req=%b addr=%h, expected 1 00000010", imem_req_o, imem_addr_o);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
        n_fail++;
        $display("FAIL rdr_stale_addr: cycle %0d got req=%b addr=%h, expected 1 00000010", i, imem_req_o, imem_addr_o);
      end
      step();
    end
    auto_gnt = 1'b1;
    wait_gnt(32'h10, "rdr_stale_gnt");
    k = 0;
    do begin step(); k++; end while (!last_gnt && k < 20);
    n_cmp++;
    if (!last_gnt || last_gnt_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL rdr_target_addr: got gnt=%b addr=%h, expected 1 00000200", last_gnt, last_gnt_addr);
    end
    wait_valid(32'h200, "rdr_target");
    drain("rdr_drain");
  endtask

  task automatic test_redirect_stall();
    do_reset();
    wait_valid(32'h4, "rs_prefill");
    pc_stall_i = 1'b1;
    step();
    step();
    n_cmp++;
    if (imem_req_o !== 1'b0 || if_id_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_skid_full: got req=%b valid=%b, expected 0 1", imem_req_o, if_id_valid_o);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    step();
    redirect_i = 1'b0;
    n_cmp++;
    if (if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP_INSTR || imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin
      n_fail++;
      $display("FAIL rs_flush: got valid=%b instr=%h req=%b addr=%h, expected 0 00000013 1 00000300",
               if_id_valid_o, if_id_instr_o, imem_req_o, imem_addr_o);
    end
    step();
    pc_stall_i = 1'b0;
    wait_valid(32'h300, "rs_target");
    drain("rs_drain");
  endtask

  task automatic test_wrap_and_reset();
    int k;
    do_reset();
    resp_delay = 3;
    wait_gnt(32'h0, "wrap_first_gnt");
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    wait_gnt(32'hFFFF_FFFC, "wrap_top_gnt");
    k = 0;
    do begin step(); k++; end while (!last_gnt && k < 20);
    n_cmp++;
    if (!last_gnt || last_gnt_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next_addr: got gnt=%b addr=%h, expected 1 00000000", last_gnt, last_gnt_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_o, if_id_valid_o} !== 2'b00 || if_id_pc_o !== 32'h0 || if_id_instr_o !== NOP_INSTR) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b valid=%b pc=%h instr=%h, expected 0 0 00000000 00000013",
               imem_req_o, if_id_valid_o, if_id_pc_o, if_id_instr_o);
    end
    pending = 1'b0; drop_next = 1'b0; sb_q.delete();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_restart: got req=%b addr=%h, expected 1 00000000", imem_req_o, imem_addr_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_stall();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
